// File: rtl/debounce_pkg.sv
// Shared constants, repeat-FSM state type and counter sizing for the input debouncer.
package debounce_pkg;

  localparam int unsigned DEF_STABLE_CYC = 100000;
  localparam int unsigned DEF_REPEAT_DLY = 50000000;
  localparam int unsigned DEF_REPEAT_PER = 10000000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_WAIT,
    RPT_REPEAT
  } rpt_state_e;

  // Bits needed to hold values 0..cyc; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: 2-flop synchroniser, stability counter, edge pulses and
// optional auto-repeat FSM for a held input.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYC = DEF_STABLE_CYC,
  parameter int unsigned REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER = DEF_REPEAT_PER,
  parameter bit          REPEAT_EN  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  localparam int unsigned CW = cnt_width(STABLE_CYC);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYC - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          w_sync;
  logic          w_commit;

  assign w_sync   = r_sync[1];
  assign w_commit = (w_sync != r_level) && (r_cnt == STABLE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw_i};
      if (w_sync == r_level || w_commit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_commit) begin
        r_level <= w_sync;
      end
      r_rise <= w_commit & w_sync;
      r_fall <= w_commit & ~w_sync;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

  if (REPEAT_EN) begin : g_rpt
    localparam int unsigned HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned HW = cnt_width(HOLD_MAX);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DLY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PER - 1);

    rpt_state_e    r_state;
    logic [HW-1:0] r_hold;
    logic          r_rpt;

    // Any commit seen while in WAIT/REPEAT is a fall, since level is high there.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= RPT_IDLE;
        r_hold  <= '0;
        r_rpt   <= 1'b0;
      end else begin
        r_rpt <= 1'b0;
        unique case (r_state)
          RPT_IDLE: begin
            if (w_commit && w_sync) begin
              r_state <= RPT_WAIT;
              r_hold  <= '0;
            end
          end
          RPT_WAIT: begin
            if (w_commit) begin
              r_state <= RPT_IDLE;
              r_hold  <= '0;
            end else if (r_hold == DLY_LAST) begin
              r_state <= RPT_REPEAT;
              r_hold  <= '0;
              r_rpt   <= 1'b1;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
          RPT_REPEAT: begin
            if (w_commit) begin
              r_state <= RPT_IDLE;
              r_hold  <= '0;
            end else if (r_hold == PER_LAST) begin
              r_hold <= '0;
              r_rpt  <= 1'b1;
            end else begin
              r_hold <= r_hold + HW'(1);
            end
          end
          default: begin
            r_state <= RPT_IDLE;
            r_hold  <= '0;
          end
        endcase
      end
    end

    assign rpt_o = r_rpt;
  end else begin : g_no_rpt
    assign rpt_o = 1'b0;
  end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer: independent per-channel lanes plus a registered
// "any input active" flag.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned     N_CH        = 12,
  parameter int unsigned     STABLE_CYC  = DEF_STABLE_CYC,
  parameter int unsigned     REPEAT_DLY  = DEF_REPEAT_DLY,
  parameter int unsigned     REPEAT_PER  = DEF_REPEAT_PER,
  parameter logic [N_CH-1:0] REPEAT_MASK = 12'h00F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] rpt_o,
  output logic            any_o
);

  logic r_any;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYC(STABLE_CYC),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER),
      .REPEAT_EN (REPEAT_MASK[i])
    ) u_channel (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (raw_i[i]),
      .level_o(level_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .rpt_o  (rpt_o[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_any <= 1'b0;
    end else begin
      r_any <= |level_o;
    end
  end

  assign any_o = r_any;

endmodule
